// File: rtl/mc_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_fsm_pkg
//  Brief    : Shared opcode, state and ALU-select encodings for the
//             multi-cycle RISC-V control FSM.
//  Revision : 1.0  initial release
// ============================================================================
package mc_control_fsm_pkg;

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] state_t;

    // RV32I major opcodes recognised by the controller
    localparam opcode_t C_OP_R      = 7'b0110011;
    localparam opcode_t C_OP_I      = 7'b0010011;
    localparam opcode_t C_OP_LOAD   = 7'b0000011;
    localparam opcode_t C_OP_STORE  = 7'b0100011;
    localparam opcode_t C_OP_BRANCH = 7'b1100011;
    localparam opcode_t C_OP_JAL    = 7'b1101111;
    localparam opcode_t C_OP_JALR   = 7'b1100111;
    localparam opcode_t C_OP_ECALL  = 7'b1110011;

    // FSM state encoding, also exported on the state port
    localparam logic [2:0] C_ST_IF   = 3'd0;
    localparam logic [2:0] C_ST_ID   = 3'd1;
    localparam logic [2:0] C_ST_EX   = 3'd2;
    localparam logic [2:0] C_ST_MEM  = 3'd3;
    localparam logic [2:0] C_ST_WB   = 3'd4;
    localparam logic [2:0] C_ST_HALT = 3'd5;
    localparam logic [2:0] C_ST_ERR  = 3'd6;

    // ALU operand A select
    localparam logic [1:0] C_ASA_PC   = 2'd0;
    localparam logic [1:0] C_ASA_RS1  = 2'd1;
    // ALU operand B select
    localparam logic [1:0] C_ASB_RS2  = 2'd0;
    localparam logic [1:0] C_ASB_FOUR = 2'd1;
    localparam logic [1:0] C_ASB_IMM  = 2'd2;
    // ALU operation class
    localparam logic [1:0] C_ALU_ADD   = 2'd0;
    localparam logic [1:0] C_ALU_BR    = 2'd1;
    localparam logic [1:0] C_ALU_FUNCT = 2'd2;

    // True for opcodes that proceed from ID into EX
    function automatic logic op_is_exec(input opcode_t op);
        logic r;
        r = 1'b0;
        case (op)
            C_OP_R, C_OP_I, C_OP_LOAD, C_OP_STORE,
            C_OP_BRANCH, C_OP_JAL, C_OP_JALR: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Brief    : Counts consecutive memory wait cycles; flags when the count
//             reaches MEM_TIMEOUT. Clear has priority over counting.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] C_LIMIT = W'(MEM_TIMEOUT);
    localparam logic [W-1:0] C_ONE   = W'(1);

    logic [W-1:0] r_count;

    assign expired = (r_count == C_LIMIT);

    // Wait counter; saturates at the limit so it can never wrap to zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (count_en && !expired) begin
            r_count <= r_count + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_fsm
//  Brief    : Multi-cycle RISC-V control unit (IF/ID/EX/MEM/WB) with memory
//             wait timeout, sticky halt/fault and retired-instruction count.
//  Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             pc_to_reg,
    output logic             pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             is_halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [6:0]       r_opcode;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_in_wait_state;
    logic             w_timer_clr;
    logic             w_timer_en;
    logic             w_expired;

    assign state   = r_state;
    assign retired = r_retired;

    // Timer runs only while an IF/MEM access is stalled; any completion or
    // state change restarts it
    assign w_in_wait_state = (r_state == C_ST_IF) || (r_state == C_ST_MEM);
    assign w_timer_en      = w_in_wait_state && !mem_ready;
    assign w_timer_clr     = mem_ready || !w_in_wait_state || (w_next_state != r_state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_timer_clr),
        .count_en (w_timer_en),
        .expired  (w_expired)
    );

    // Next-state and instruction-retire decision
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            C_ST_IF: begin
                if (mem_ready)      w_next_state = C_ST_ID;
                else if (w_expired) w_next_state = C_ST_ERR;
            end
            C_ST_ID: begin
                if (op_is_exec(opcode)) begin
                    w_next_state = C_ST_EX;
                end else if (opcode == C_OP_ECALL) begin
                    if (halt_req) begin
                        w_next_state = C_ST_HALT;
                    end else begin
                        w_next_state = C_ST_IF;
                        w_retire     = 1'b1;
                    end
                end else begin
                    w_next_state = C_ST_ERR;
                end
            end
            C_ST_EX: begin
                case (r_opcode)
                    C_OP_R, C_OP_I, C_OP_JAL, C_OP_JALR: w_next_state = C_ST_WB;
                    C_OP_LOAD, C_OP_STORE:               w_next_state = C_ST_MEM;
                    C_OP_BRANCH: begin
                        w_next_state = C_ST_IF;
                        w_retire     = 1'b1;
                    end
                    default:                             w_next_state = C_ST_ERR;
                endcase
            end
            C_ST_MEM: begin
                if (mem_ready) begin
                    if (r_opcode == C_OP_LOAD) begin
                        w_next_state = C_ST_WB;
                    end else begin
                        w_next_state = C_ST_IF;
                        w_retire     = 1'b1;
                    end
                end else if (w_expired) begin
                    w_next_state = C_ST_ERR;
                end
            end
            C_ST_WB: begin
                w_next_state = C_ST_IF;
                w_retire     = 1'b1;
            end
            C_ST_HALT: w_next_state = C_ST_HALT;
            C_ST_ERR:  w_next_state = C_ST_ERR;
            default:   w_next_state = C_ST_ERR;
        endcase
    end

    // State, latched opcode and retired counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= C_ST_IF;
            r_opcode  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == C_ST_ID) begin
                r_opcode <= opcode;
            end
            if (w_retire) begin
                r_retired <= r_retired + C_CNT_ONE;
            end
        end
    end

    // Datapath control decode; write enables are suppressed while in reset
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        pc_to_reg     = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = C_ASA_PC;
        alu_src_b     = C_ASB_RS2;
        alu_op        = C_ALU_ADD;
        is_halted     = (r_state == C_ST_HALT) || (r_state == C_ST_ERR);
        fault         = (r_state == C_ST_ERR);
        case (r_state)
            C_ST_IF: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_a = C_ASA_PC;
                alu_src_b = C_ASB_FOUR;
                alu_op    = C_ALU_ADD;
            end
            C_ST_EX: begin
                case (r_opcode)
                    C_OP_R: begin
                        alu_src_a = C_ASA_RS1;
                        alu_src_b = C_ASB_RS2;
                        alu_op    = C_ALU_FUNCT;
                    end
                    C_OP_I: begin
                        alu_src_a = C_ASA_RS1;
                        alu_src_b = C_ASB_IMM;
                        alu_op    = C_ALU_FUNCT;
                    end
                    C_OP_LOAD, C_OP_STORE, C_OP_JALR: begin
                        alu_src_a = C_ASA_RS1;
                        alu_src_b = C_ASB_IMM;
                        alu_op    = C_ALU_ADD;
                    end
                    C_OP_JAL: begin
                        alu_src_a = C_ASA_PC;
                        alu_src_b = C_ASB_IMM;
                        alu_op    = C_ALU_ADD;
                    end
                    C_OP_BRANCH: begin
                        alu_src_a     = C_ASA_RS1;
                        alu_src_b     = C_ASB_RS2;
                        alu_op        = C_ALU_BR;
                        pc_write_cond = bcond;
                        pc_source     = 1'b1;
                    end
                    default: ;
                endcase
            end
            C_ST_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (r_opcode == C_OP_LOAD);
                mem_write = (r_opcode == C_OP_STORE);
            end
            C_ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_opcode == C_OP_LOAD);
                if ((r_opcode == C_OP_JAL) || (r_opcode == C_OP_JALR)) begin
                    pc_to_reg = 1'b1;
                    pc_write  = 1'b1;
                    pc_source = 1'b0;
                end
            end
            default: ;
        endcase
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control_fsm
//  Brief    : Randomised instruction-stream bench for mc_control_fsm with an
//             instruction-level expectation model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;
    import mc_control_fsm_pkg::*;

    localparam int TMO   = 4;
    localparam int CW    = 4;

    // instruction kinds and phases of the reference model
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                   K_JAL = 5, K_JALR = 6, K_ECALL = 7, K_ILL = 8;
    localparam int P_NONE = 0, P_IF = 1, P_ID = 2, P_EX = 3, P_MEM = 4,
                   P_WB = 5, P_HALT = 6, P_ERR = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic          bcond = 1'b0;
    logic          halt_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic          mem_to_reg, reg_write, pc_to_reg, pc_source;
    logic [1:0]    alu_src_a, alu_src_b, alu_op;
    logic          is_halted, fault;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic [17:0]   ctl_vec;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_ret = 0;
    int term = P_NONE;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .halt_req(halt_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_to_reg(pc_to_reg),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .is_halted(is_halted), .fault(fault),
        .state(state), .retired(retired)
    );

    assign ctl_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_write, pc_to_reg, pc_source,
                      alu_src_a, alu_src_b, alu_op, is_halted, fault};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] opc(input int k);
        case (k)
            K_R:     return C_OP_R;
            K_I:     return C_OP_I;
            K_LD:    return C_OP_LOAD;
            K_ST:    return C_OP_STORE;
            K_BR:    return C_OP_BRANCH;
            K_JAL:   return C_OP_JAL;
            K_JALR:  return C_OP_JALR;
            K_ECALL: return C_OP_ECALL;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [2:0] exp_state(input int ph);
        case (ph)
            P_IF:    return C_ST_IF;
            P_ID:    return C_ST_ID;
            P_EX:    return C_ST_EX;
            P_MEM:   return C_ST_MEM;
            P_WB:    return C_ST_WB;
            P_HALT:  return C_ST_HALT;
            default: return C_ST_ERR;
        endcase
    endfunction

    // Expected control outputs, straight from the per-phase control table
    function automatic logic [17:0] exp_ctl(input int ph, input int k, input logic rdy, input logic bc);
        logic pw, pwc, iod, mr, mw, irw, m2r, rw, p2r, ps, h, f;
        logic [1:0] a, b, op;
        {pw, pwc, iod, mr, mw, irw, m2r, rw, p2r, ps, h, f} = '0;
        a = 2'd0; b = 2'd0; op = 2'd0;
        case (ph)
            P_IF: begin mr = 1; irw = rdy; pw = rdy; b = 2'd1; end
            P_EX: begin
                case (k)
                    K_R:         begin a = 1; b = 0; op = 2; end
                    K_I:         begin a = 1; b = 2; op = 2; end
                    K_LD, K_ST:  begin a = 1; b = 2; op = 0; end
                    K_BR:        begin a = 1; b = 0; op = 1; pwc = bc; ps = 1; end
                    K_JAL:       begin a = 0; b = 2; op = 0; end
                    K_JALR:      begin a = 1; b = 2; op = 0; end
                    default: ;
                endcase
            end
            P_MEM: begin iod = 1; mr = (k == K_LD); mw = (k == K_ST); end
            P_WB: begin
                rw = 1; m2r = (k == K_LD);
                if (k == K_JAL || k == K_JALR) begin p2r = 1; pw = 1; end
            end
            P_HALT: h = 1;
            P_ERR:  begin h = 1; f = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, p2r, ps, a, b, op, h, f};
    endfunction

    // One clock: apply mem_ready, check outputs mid-cycle, advance past the edge
    task automatic step(input int ph, input int k, input logic rdy);
        mem_ready = rdy;
        #1;
        chk($sformatf("state ph%0d k%0d", ph, k), 32'(state), 32'(exp_state(ph)));
        chk($sformatf("ctl ph%0d k%0d", ph, k), 32'(ctl_vec), 32'(exp_ctl(ph, k, rdy, bcond)));
        chk("retired", 32'(retired), 32'(exp_ret % (1 << CW)));
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction with d_if / d_mem stalled cycles; sets term on HALT/ERR
    task automatic run_instr(input int k, input int d_if, input int d_mem,
                             input logic bc, input logic hq);
        bcond = $urandom; halt_req = $urandom;
        for (int w = 0; w < d_if; w++) begin
            opcode = 7'($urandom);
            step(P_IF, k, 1'b0);
            if (w == TMO) begin term = P_ERR; return; end
        end
        opcode = 7'($urandom);
        step(P_IF, k, 1'b1);
        opcode = opc(k); bcond = bc; halt_req = hq;
        step(P_ID, k, 1'($urandom));
        if (k == K_ECALL) begin
            if (hq) term = P_HALT;
            else    exp_ret++;
            return;
        end
        if (k == K_ILL) begin term = P_ERR; return; end
        step(P_EX, k, 1'($urandom));
        if (k == K_BR) begin exp_ret++; return; end
        if (k == K_LD || k == K_ST) begin
            for (int w = 0; w < d_mem; w++) begin
                step(P_MEM, k, 1'b0);
                if (w == TMO) begin term = P_ERR; return; end
            end
            step(P_MEM, k, 1'b1);
            if (k == K_ST) begin exp_ret++; return; end
        end
        step(P_WB, k, 1'($urandom));
        exp_ret++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            opcode = 7'($urandom); bcond = $urandom; halt_req = $urandom;
            step(term, K_R, 1'($urandom));
        end
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b1; mem_ready = rdy; bcond = 1'b1;
        #1;
        chk("rst_we", 32'({pc_write, pc_write_cond, ir_write, mem_write, reg_write}), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_ret = 0; term = P_NONE;
        chk("rst_state", 32'(state), 32'(C_ST_IF));
        chk("rst_ret", 32'(retired), 32'd0);
        chk("rst_flags", 32'({is_halted, fault}), 32'd0);
    endtask

    initial begin
        int k;
        @(posedge clk);
        #2;
        do_reset(1'b0);

        // directed: load with 3 MEM waits, branch, store, jumps, ecall return
        run_instr(K_LD, 0, 3, 1'b0, 1'b0);
        chk("load_ret", 32'(retired), 32'd1);
        run_instr(K_BR, 0, 0, 1'b1, 1'b0);
        run_instr(K_ST, 0, 0, 1'b0, 1'b0);
        run_instr(K_JAL, 1, 0, 1'b0, 1'b0);
        run_instr(K_JALR, 0, 0, 1'b0, 1'b0);
        run_instr(K_ECALL, 0, 0, 1'b0, 1'b0);
        run_instr(K_BR, 2, 0, 1'b0, 1'b0);

        // random legal instruction stream, stalls up to the timeout boundary
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 7);
            run_instr(k, $urandom_range(0, TMO), $urandom_range(0, TMO),
                      1'($urandom), 1'b0);
        end

        // counter wrap: 17 R-type from reset
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) run_instr(K_R, 0, 0, 1'b0, 1'b0);
        chk("wrap", 32'(retired), 32'd1);

        // ready on exactly the last allowed cycle, then timeout in IF
        run_instr(K_I, TMO, 0, 1'b0, 1'b0);
        run_instr(K_R, TMO + 1, 0, 1'b0, 1'b0);
        chk("if_tmo_term", 32'(term), 32'(P_ERR));
        idle(5);
        do_reset(1'b1);

        // timeout in MEM
        run_instr(K_LD, 0, TMO + 1, 1'b0, 1'b0);
        idle(3);
        do_reset(1'b0);

        // halting ecall, held for 20 cycles
        run_instr(K_R, 0, 0, 1'b0, 1'b0);
        run_instr(K_ECALL, 0, 0, 1'b0, 1'b1);
        idle(20);
        do_reset(1'b1);

        // illegal opcode
        run_instr(K_ILL, 0, 0, 1'b0, 1'b0);
        idle(4);
        do_reset(1'b0);

        // reset pulsed mid-MEM of a store with mem_ready high
        run_instr(K_R, 0, 0, 1'b0, 1'b0);
        opcode = 7'($urandom); step(P_IF, K_ST, 1'b1);
        opcode = C_OP_STORE;   step(P_ID, K_ST, 1'b0);
        step(P_EX, K_ST, 1'b0);
        step(P_MEM, K_ST, 1'b0);
        do_reset(1'b1);
        run_instr(K_ST, 0, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
